// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host receiver: synchronizes the raw PS/2 lines, filters
// glitches on the PS/2 clock, and deframes 11-bit frames into scancodes.
module ps2_frame_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ready,
  output logic [7:0] scancode,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_clk, filt_prev;
  logic [7:0]    filt_cnt;
  logic          fall;

  state_t        state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic          par, par_n;
  logic [TW-1:0] tmo, tmo_n;
  logic          ready_n, err_n;
  logic [7:0]    code_n;

  // Two-flop synchronizers; idle level of both PS/2 lines is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Glitch filter: adopt a new clock level only after it persists FILTER_LEN cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      filt_prev <= filt_clk;
      if (clk_s2 != filt_clk) begin
        if (filt_cnt == 8'(FILTER_LEN - 1)) begin
          filt_clk <= clk_s2;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + 8'd1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign fall = filt_prev & ~filt_clk;

  // Frame state, shift register, timeout counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      par       <= 1'b0;
      tmo       <= '0;
      ready     <= 1'b0;
      frame_err <= 1'b0;
      scancode  <= '0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      par       <= par_n;
      tmo       <= tmo_n;
      ready     <= ready_n;
      frame_err <= err_n;
      scancode  <= code_n;
    end
  end

  // Next-state logic: bit sampling on filtered falling edges, frame checks, timeout.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    par_n     = par;
    tmo_n     = '0;
    ready_n   = 1'b0;
    err_n     = 1'b0;
    code_n    = scancode;

    if (state != IDLE) tmo_n = tmo + TW'(1);

    case (state)
      IDLE: begin
        if (fall) begin
          if (!dat_s2) begin
            state_n   = DATA;
            bit_cnt_n = '0;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      DATA: begin
        if (fall) begin
          shift_n = {dat_s2, shift[7:1]};
          if (bit_cnt == 3'd7) begin
            state_n   = PARITY;
            bit_cnt_n = '0;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end
      end
      PARITY: begin
        if (fall) begin
          par_n   = dat_s2;
          state_n = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          if (dat_s2 && (^{shift, par})) begin
            code_n  = shift;
            ready_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Timeout override: an edge restarts the count, expiry abandons the frame.
    if (state != IDLE) begin
      if (fall) begin
        tmo_n = '0;
      end else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
        state_n   = IDLE;
        bit_cnt_n = '0;
        tmo_n     = '0;
        err_n     = 1'b1;
      end
    end
  end

endmodule
